// File: rtl/config_pkg.sv
// Core configuration package.
// Holds the configuration record that sizes instruction and PC widths and the
// fetch group width. EmptyCfg is the default used when no core config is given.
package config_pkg;

    typedef struct packed {
        int unsigned ILEN;
        int unsigned PLEN;
        int unsigned INSTR_PER_FETCH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{ILEN: 32, PLEN: 32, INSTR_PER_FETCH: 4};

endpackage

// File: rtl/instr_queue_pkg.sv
// Instruction queue shared types.
// The entry record is shared with decode so it can consume queue entries
// without re-packing. Widths follow the default core configuration.
package instr_queue_pkg;

    localparam int unsigned ENTRY_ILEN = config_pkg::EmptyCfg.ILEN;
    localparam int unsigned ENTRY_PLEN = config_pkg::EmptyCfg.PLEN;

    typedef struct packed {
        logic [ENTRY_ILEN-1:0] instr;
        logic [ENTRY_PLEN-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_compact.sv
// Fetch-slot compaction, purely combinational.
// For every slot of the fetch group it reports how many valid slots precede it
// (its write offset from the queue tail) and the total number of valid slots.
// Ports:
//   i_mask     FETCH_W                 per-slot valid mask
//   o_offsets  FETCH_W x clog2(FETCH_W+1)  write offset of each slot
//   o_count    clog2(FETCH_W+1)        popcount of i_mask
module iq_compact #(
    parameter int unsigned FETCH_W = 4
) (
    input  logic [FETCH_W-1:0]                      i_mask,
    output logic [FETCH_W*$clog2(FETCH_W+1)-1:0]    o_offsets,
    output logic [$clog2(FETCH_W+1)-1:0]            o_count
);

    localparam int unsigned CW = $clog2(FETCH_W + 1);

    logic [CW-1:0] w_acc;

    // Running prefix sum: a slot's offset is the number of set bits below it.
    always_comb begin
        w_acc     = '0;
        o_offsets = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            o_offsets[k*CW +: CW] = w_acc;
            w_acc                 = w_acc + CW'(i_mask[k]);
        end
        o_count = w_acc;
    end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of flop entries. Fetch writes a whole (possibly holey) group
// per cycle, compacted into consecutive entries; decode sees up to DECODE_W
// entries from the head and consumes a variable number per cycle.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop all queued and incoming instructions
//   fe_valid_i/fe_ready_o fetch handshake (ready = room for a full group)
//   fe_slot_mask_i       per-slot valid within the fetch group
//   fe_instrs_i, fe_pc_i instruction words and PC of slot 0
//   ibuf_valid_o         thermometer mask of valid output slots
//   ibuf_instrs_o/pcs_o  entries at head+j
//   ibuf_accept_i        number of output slots consumed
//   count_o              current occupancy
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg      = config_pkg::EmptyCfg,
    parameter int unsigned      DEPTH    = 16,
    parameter int unsigned      FETCH_W  = Cfg.INSTR_PER_FETCH,
    parameter int unsigned      DECODE_W = Cfg.INSTR_PER_FETCH
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                fe_valid_i,
    output logic                                fe_ready_o,
    input  logic [FETCH_W-1:0]                  fe_slot_mask_i,
    input  logic [FETCH_W*Cfg.ILEN-1:0]         fe_instrs_i,
    input  logic [Cfg.PLEN-1:0]                 fe_pc_i,
    output logic [DECODE_W-1:0]                 ibuf_valid_o,
    output logic [DECODE_W*Cfg.ILEN-1:0]        ibuf_instrs_o,
    output logic [DECODE_W*Cfg.PLEN-1:0]        ibuf_pcs_o,
    input  logic [$clog2(DECODE_W+1)-1:0]       ibuf_accept_i,
    output logic [$clog2(DEPTH+1)-1:0]          count_o
);

    localparam int unsigned ILEN   = Cfg.ILEN;
    localparam int unsigned PLEN   = Cfg.PLEN;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned FCNT_W = $clog2(FETCH_W + 1);

    iq_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [FETCH_W*FCNT_W-1:0] w_offsets;
    logic [FCNT_W-1:0]         w_group_cnt;
    logic [CNT_W-1:0]          w_free;
    logic [CNT_W-1:0]          w_vis_n;
    logic [CNT_W-1:0]          w_acc_ext;
    logic [CNT_W-1:0]          w_deq_n;
    logic [CNT_W-1:0]          w_enq_n;
    logic                      w_enq;

    iq_compact #(
        .FETCH_W (FETCH_W)
    ) u_compact (
        .i_mask    (fe_slot_mask_i),
        .o_offsets (w_offsets),
        .o_count   (w_group_cnt)
    );

    // Ready depends on registered occupancy only, so decode's accept never
    // feeds back combinationally into fetch.
    assign w_free     = CNT_W'(DEPTH) - r_count;
    assign fe_ready_o = (w_free >= CNT_W'(FETCH_W));
    assign count_o    = r_count;

    // Over-accepting is clamped to the number of slots actually shown.
    assign w_vis_n   = (r_count > CNT_W'(DECODE_W)) ? CNT_W'(DECODE_W) : r_count;
    assign w_acc_ext = CNT_W'(ibuf_accept_i);
    assign w_deq_n   = (w_acc_ext > w_vis_n) ? w_vis_n : w_acc_ext;

    assign w_enq   = fe_valid_i && fe_ready_o && !flush_i;
    assign w_enq_n = w_enq ? CNT_W'(w_group_cnt) : '0;

    for (genvar j = 0; j < DECODE_W; j++) begin : g_out
        logic [PTR_W-1:0] w_idx;
        assign w_idx                          = r_head + PTR_W'(j);
        assign ibuf_valid_o[j]                = (r_count > CNT_W'(j));
        assign ibuf_instrs_o[j*ILEN +: ILEN]  = r_mem[w_idx].instr;
        assign ibuf_pcs_o[j*PLEN +: PLEN]     = r_mem[w_idx].pc;
    end

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (fe_slot_mask_i[k]) begin
                    r_mem[r_tail + PTR_W'(w_offsets[k*FCNT_W +: FCNT_W])] <= '{
                        instr: fe_instrs_i[k*ILEN +: ILEN],
                        pc:    fe_pc_i + PLEN'(4 * k)
                    };
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH=16, FETCH_W=4, DECODE_W=4).
// A queue model holds expected entries: pushed when fetch groups are accepted,
// popped when decode consumes them; visible slots are compared every cycle.
module tb_instr_queue;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         fe_valid;
    logic         fe_ready;
    logic [3:0]   mask;
    logic [127:0] instrs;
    logic [31:0]  pc;
    logic [3:0]   ibuf_valid;
    logic [127:0] ibuf_instrs;
    logic [127:0] ibuf_pcs;
    logic [2:0]   accept;
    logic [4:0]   count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    always #5 clk = ~clk;

    instr_queue #(
        .DEPTH    (16),
        .FETCH_W  (4),
        .DECODE_W (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .fe_valid_i     (fe_valid),
        .fe_ready_o     (fe_ready),
        .fe_slot_mask_i (mask),
        .fe_instrs_i    (instrs),
        .fe_pc_i        (pc),
        .ibuf_valid_o   (ibuf_valid),
        .ibuf_instrs_o  (ibuf_instrs),
        .ibuf_pcs_o     (ibuf_pcs),
        .ibuf_accept_i  (accept),
        .count_o        (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_visible();
        int sz;
        int nv;
        sz = exp_q.size();
        nv = (sz < 4) ? sz : 4;
        chk("count", 64'(count), 64'(sz));
        chk("ready", 64'(fe_ready), 64'((16 - sz) >= 4));
        chk("valid", 64'(ibuf_valid), 64'((1 << nv) - 1));
        for (int j = 0; j < nv; j++) begin
            chk($sformatf("instr%0d", j), 64'(ibuf_instrs[j*32 +: 32]), 64'(exp_q[j].instr));
            chk($sformatf("pc%0d", j), 64'(ibuf_pcs[j*32 +: 32]), 64'(exp_q[j].pc));
        end
    endtask

    // One cycle: check current outputs, drive inputs, advance the model.
    task automatic step(input logic v, input logic [3:0] m, input logic [31:0] p,
                        input int acc, input logic fl);
        int          nv;
        int          deq;
        logic        rdy;
        logic [31:0] words [4];
        check_visible();
        nv  = (exp_q.size() < 4) ? exp_q.size() : 4;
        rdy = ((16 - exp_q.size()) >= 4);
        for (int k = 0; k < 4; k++) begin
            words[k] = 32'(seq * 16 + k) ^ 32'h5A00_0000;
            instrs[k*32 +: 32] = words[k];
        end
        seq++;
        fe_valid = v;
        mask     = m;
        pc       = p;
        accept   = 3'(acc);
        flush    = fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            deq = (acc < nv) ? acc : nv;
            repeat (deq) void'(exp_q.pop_front());
            if (v && rdy) begin
                for (int k = 0; k < 4; k++) begin
                    if (m[k]) exp_q.push_back('{instr: words[k], pc: p + 32'(4 * k)});
                end
            end
        end
        @(negedge clk);
        fe_valid = 1'b0;
        mask     = '0;
        accept   = '0;
        flush    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        fe_valid = 1'b0;
        mask     = '0;
        instrs   = '0;
        pc       = '0;
        accept   = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(ibuf_valid), 64'd0);
        chk("rst_ready", 64'(fe_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Full group after reset
        step(1'b1, 4'b1111, 32'h8000_0000, 0, 1'b0);
        chk("full_valid", 64'(ibuf_valid), 64'hF);
        chk("full_count", 64'(count), 64'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("full_pc%0d", j), 64'(ibuf_pcs[j*32 +: 32]), 64'(32'h8000_0000 + 32'(4 * j)));
        step(1'b0, 4'b0000, 32'h0, 4, 1'b0);

        // Holey mask compacts to the head
        step(1'b1, 4'b1010, 32'h100, 0, 1'b0);
        chk("holey_valid", 64'(ibuf_valid), 64'h3);
        chk("holey_pc0", 64'(ibuf_pcs[31:0]), 64'h104);
        chk("holey_pc1", 64'(ibuf_pcs[63:32]), 64'h10C);
        step(1'b1, 4'b0000, 32'h200, 4, 1'b0);

        // Fill to full, then drain while fetch stays valid
        for (int g = 0; g < 4; g++) step(1'b1, 4'b1111, 32'h1000 + 32'(g * 16), 0, 1'b0);
        chk("full16_count", 64'(count), 64'd16);
        chk("full16_ready", 64'(fe_ready), 64'd0);
        step(1'b1, 4'b1111, 32'h2000, 4, 1'b0);
        chk("drain_count", 64'(count), 64'd12);
        chk("drain_ready", 64'(fe_ready), 64'd1);
        step(1'b1, 4'b1111, 32'h2000, 4, 1'b0);
        chk("steady_count", 64'(count), 64'd12);

        // Move head to 10, refill to 12 and drain across the wrap
        step(1'b0, 4'b0000, 32'h0, 0, 1'b1);
        step(1'b1, 4'b1111, 32'h3000, 0, 1'b0);
        step(1'b1, 4'b1111, 32'h3010, 0, 1'b0);
        step(1'b1, 4'b0011, 32'h3020, 0, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 4, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 4, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 2, 1'b0);
        for (int g = 0; g < 3; g++) step(1'b1, 4'b1111, 32'h4000 + 32'(g * 16), 0, 1'b0);
        chk("wrap_fill", 64'(count), 64'd12);
        for (int g = 0; g < 4; g++) step(1'b0, 4'b0000, 32'h0, 3, 1'b0);
        chk("wrap_empty", 64'(count), 64'd0);

        // Flush beats simultaneous enqueue and dequeue
        step(1'b1, 4'b1111, 32'h5000, 0, 1'b0);
        step(1'b1, 4'b1111, 32'h5010, 0, 1'b0);
        step(1'b1, 4'b0001, 32'h5020, 0, 1'b0);
        chk("pre_flush", 64'(count), 64'd9);
        step(1'b1, 4'b1111, 32'h5030, 2, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(ibuf_valid), 64'd0);

        // Asynchronous reset mid-operation
        step(1'b1, 4'b1111, 32'h6000, 0, 1'b0);
        step(1'b1, 4'b0111, 32'h6010, 0, 1'b0);
        chk("pre_rst", 64'(count), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(ibuf_valid), 64'd0);
        chk("arst_ready", 64'(fe_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b1111, 32'hC000_0000, 0, 1'b0);
        chk("post_rst_idx0", 64'(dut.r_mem[0].pc), 64'hC000_0000);
        chk("post_rst_pc0", 64'(ibuf_pcs[31:0]), 64'hC000_0000);

        // Random traffic, including over-accept and occasional flush
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 32'($urandom) & 32'hFFFF_FFF0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 29) == 0));
        end
        repeat (5) step(1'b0, 4'b0000, 32'h0, 4, 1'b0);
        check_visible();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter Cfg, default config_pkg::EmptyCfg, supplies ILEN, PLEN, INSTR_PER_FETCH.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >= 2*max(FETCH_W, DECODE_W).
REQ-003 Parameter FETCH_W, default Cfg.INSTR_PER_FETCH, number of enqueue slots per cycle.
REQ-004 Parameter DECODE_W, default Cfg.INSTR_PER_FETCH, number of dequeue slots per cycle; independent of FETCH_W.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 flush_i  input  1  discard all queued and incoming instructions.
REQ-008 fe_valid_i  input  1  fetch group present.
REQ-009 fe_ready_o  output  1  queue can accept a full fetch group.
REQ-010 fe_slot_mask_i  input  FETCH_W  per-slot valid within the group; arbitrary pattern, holes allowed.
REQ-011 fe_instrs_i  input  FETCH_W x ILEN  instruction words.
REQ-012 fe_pc_i  input  PLEN  PC of slot 0; slot k PC = fe_pc_i + 4*k.
REQ-013 ibuf_valid_o  output  DECODE_W  thermometer mask; bit j set iff count > j.
REQ-014 ibuf_instrs_o  output  DECODE_W x ILEN  instructions at head+j.
REQ-015 ibuf_pcs_o  output  DECODE_W x PLEN  PCs at head+j.
REQ-016 ibuf_accept_i  input  clog2(DECODE_W+1)  number of output slots consumed this cycle.
REQ-017 count_o  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-018 Storage is a circular buffer with head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
REQ-019 fe_ready_o is 1 iff DEPTH - count >= FETCH_W, computed from registered count only; no combinational path from ibuf_accept_i.
REQ-020 Enqueue fires when fe_valid_i && fe_ready_o && !flush_i; popcount(fe_slot_mask_i) entries are written.
REQ-021 Masked slots are compacted in ascending slot order into tail, tail+1, ..., each carrying its own slot PC.
REQ-022 Enqueue with all-zero mask is a legal no-op.
REQ-023 Enqueued entries appear on outputs the cycle after the enqueue edge; no same-cycle bypass.
REQ-024 Output slot j is driven combinationally from entry head+j (mod DEPTH); contents of invalid slots are don't-care.
REQ-025 Dequeue removes ibuf_accept_i entries; ibuf_accept_i exceeding popcount(ibuf_valid_o) is a protocol violation; the design clamps it to the valid count.
REQ-026 Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n; full-to-drain and empty-to-fill both legal in one cycle.
REQ-027 flush_i has priority: next cycle head = tail = 0, count = 0; same-cycle enqueue and dequeue are ignored.
REQ-028 Occupancy never exceeds DEPTH and never underflows.

Reset
REQ-029 On rst_ni low, asynchronously: head = 0, tail = 0, count = 0.
REQ-030 During and after reset: fe_ready_o = 1, ibuf_valid_o = 0, count_o = 0; storage array is not reset.
REQ-031 Reset asserted mid-operation discards all content identically to flush.

Structure
REQ-032 Entry typedef (instr ILEN, pc PLEN) lives in a shared package so decode consumes it unmodified.
REQ-033 Compaction (mask -> per-slot write offset + popcount) is one sub-module, iq_compact, purely combinational.
REQ-034 No other sub-modules; the storage array is flops, not SRAM.

Verification (DEPTH=16, FETCH_W=4, DECODE_W=4)
REQ-035 Reset, then mask 4'b1111, PC 0x8000_0000 -> next cycle ibuf_valid_o=4'b1111, PCs 0x8000_0000..0x8000_000C, count_o=4.
REQ-036 Mask 4'b1010, PC 0x100 -> slots 0/1 hold PCs 0x104/0x10C; ibuf_valid_o=4'b0011.
REQ-037 Four full groups with accept=0 -> count_o=16, fe_ready_o=0; then accept=4 with fe_valid_i held -> count stays 12 one cycle later, fe_ready_o back to 1 with no stall cycle lost.
REQ-038 Fill to 12 from head 10, drain by accept=3 repeatedly -> PCs in order across wrap at index 15->0, no loss or duplication.
REQ-039 flush_i with count=9 and fe_valid_i=1, accept=2 in same cycle -> next cycle count_o=0, ibuf_valid_o=0, fetch group dropped.
REQ-040 rst_ni low for one cycle at count=7 -> outputs at reset values immediately (asynchronous); first post-reset enqueue lands at index 0.
